// File: rtl/mem_stage.sv
// MEM stage of the MIPS core: word-addressed data memory plus the MEM/WB
// pipeline register feeding write-back one clock after EX/MEM.
module mem_stage #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  wbi,
   input  logic [4:0]  regaddr,
   input  logic        M,
   input  logic [31:0] data,
   input  logic [31:0] dataaddr,
   output logic [1:0]  wbo,
   output logic [31:0] datafrommem,
   output logic [31:0] datafromimm,
   output logic [4:0]  regaddrout
);

   // Only the low AW address bits index the array, so any address wraps
   // modulo DEPTH and can never reach outside it.
   logic [AW-1:0] idx;
   assign idx = dataaddr[AW-1:0];

   // Power-up contents are zero; rst deliberately leaves the array alone.
   logic [31:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (!rst && M) begin
         mem[idx] <= data;
      end
   end

   // Read is write-first: a store in the same cycle is what WB sees.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbo         <= '0;
         regaddrout  <= '0;
         datafromimm <= '0;
         datafrommem <= '0;
      end else begin
         wbo         <= wbi;
         regaddrout  <= regaddr;
         datafromimm <= dataaddr;
         datafrommem <= M ? data : mem[idx];
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, store/load, wrap-around,
// reset priority, back-to-back writes and a streaming run.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wbi;
   logic [4:0]  regaddr;
   logic        M;
   logic [31:0] data;
   logic [31:0] dataaddr;
   logic [1:0]  wbo;
   logic [31:0] datafrommem;
   logic [31:0] datafromimm;
   logic [4:0]  regaddrout;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   mem_stage #(.DEPTH(32), .AW(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .wbi         (wbi),
      .regaddr     (regaddr),
      .M           (M),
      .data        (data),
      .dataaddr    (dataaddr),
      .wbo         (wbo),
      .datafrommem (datafrommem),
      .datafromimm (datafromimm),
      .regaddrout  (regaddrout)
   );

   // Advance one rising edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wbi = 2'd3; regaddr = 5'd9; M = 1'b1;
      data = 32'h5555_AAAA; dataaddr = 32'd1;
      step();
      step();
      n_cmp++; if (wbo !== 2'd0) begin n_fail++; $display("FAIL reset_wbo: got %0d want 0", wbo); end
      n_cmp++; if (regaddrout !== 5'd0) begin n_fail++; $display("FAIL reset_regaddrout: got %0d want 0", regaddrout); end
      n_cmp++; if (datafromimm !== 32'd0) begin n_fail++; $display("FAIL reset_datafromimm: got %h want 0", datafromimm); end
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL reset_datafrommem: got %h want 0", datafrommem); end
      rst = 1'b0; M = 1'b0; wbi = 2'd0; regaddr = 5'd0; dataaddr = 32'd1;
      step();
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr1: got %h want 0", datafrommem); end
   endtask

   task automatic test_pass_through();
      wbi = 2'd3; regaddr = 5'd13; dataaddr = 32'd1; M = 1'b0; data = 32'hFFFF_FFFF;
      step();
      n_cmp++; if (wbo !== 2'd3) begin n_fail++; $display("FAIL pass_wbo: got %0d want 3", wbo); end
      n_cmp++; if (regaddrout !== 5'd13) begin n_fail++; $display("FAIL pass_regaddrout: got %0d want 13", regaddrout); end
      n_cmp++; if (datafromimm !== 32'd1) begin n_fail++; $display("FAIL pass_datafromimm: got %h want 1", datafromimm); end
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL pass_datafrommem: got %h want 0", datafrommem); end
   endtask

   task automatic test_store_load();
      wbi = 2'd1; regaddr = 5'd2; data = 32'd10; dataaddr = 32'd1; M = 1'b1;
      step();
      n_cmp++; if (datafrommem !== 32'd10) begin n_fail++; $display("FAIL store_write_first: got %0d want 10", datafrommem); end
      M = 1'b0; data = 32'd99;
      step();
      n_cmp++; if (datafrommem !== 32'd10) begin n_fail++; $display("FAIL store_hold: got %0d want 10", datafrommem); end
      dataaddr = 32'd2;
      step();
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL store_other_addr: got %0d want 0", datafrommem); end
      n_cmp++; if (datafromimm !== 32'd2) begin n_fail++; $display("FAIL store_datafromimm: got %0d want 2", datafromimm); end
   endtask

   task automatic test_wrap();
      data = 32'hDEAD_BEEF; dataaddr = 32'd33; M = 1'b1;
      step();
      n_cmp++; if (datafrommem !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wrap_write_first: got %h want deadbeef", datafrommem); end
      n_cmp++; if (datafromimm !== 32'd33) begin n_fail++; $display("FAIL wrap_datafromimm: got %0d want 33", datafromimm); end
      M = 1'b0; data = 32'd0; dataaddr = 32'd1;
      step();
      n_cmp++; if (datafrommem !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wrap_read_addr1: got %h want deadbeef", datafrommem); end
      dataaddr = 32'hFFFF_FFE1;
      step();
      n_cmp++; if (datafrommem !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wrap_high_bits: got %h want deadbeef", datafrommem); end
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; M = 1'b1; dataaddr = 32'd4; data = 32'd7; wbi = 2'd2; regaddr = 5'd31;
      step();
      n_cmp++; if (wbo !== 2'd0) begin n_fail++; $display("FAIL rprio_wbo: got %0d want 0", wbo); end
      n_cmp++; if (regaddrout !== 5'd0) begin n_fail++; $display("FAIL rprio_regaddrout: got %0d want 0", regaddrout); end
      n_cmp++; if (datafromimm !== 32'd0) begin n_fail++; $display("FAIL rprio_datafromimm: got %h want 0", datafromimm); end
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL rprio_datafrommem: got %h want 0", datafrommem); end
      rst = 1'b0; M = 1'b0; data = 32'd0;
      step();
      n_cmp++; if (datafrommem !== 32'd0) begin n_fail++; $display("FAIL rprio_no_write: got %0d want 0", datafrommem); end
      n_cmp++; if (wbo !== 2'd2) begin n_fail++; $display("FAIL rprio_fresh_wbo: got %0d want 2", wbo); end
      dataaddr = 32'd1;
      step();
      n_cmp++; if (datafrommem !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rprio_mem_kept: got %h want deadbeef", datafrommem); end
   endtask

   task automatic test_back_to_back();
      dataaddr = 32'd7; M = 1'b1; data = 32'd5;
      step();
      n_cmp++; if (datafrommem !== 32'd5) begin n_fail++; $display("FAIL b2b_first: got %0d want 5", datafrommem); end
      data = 32'd6;
      step();
      n_cmp++; if (datafrommem !== 32'd6) begin n_fail++; $display("FAIL b2b_second: got %0d want 6", datafrommem); end
      M = 1'b0; data = 32'd0;
      step();
      n_cmp++; if (datafrommem !== 32'd6) begin n_fail++; $display("FAIL b2b_last_wins: got %0d want 6", datafrommem); end
   endtask

   // Memory now holds addr1=DEADBEEF, addr7=6, everything else 0.
   task automatic test_streaming();
      logic [31:0] exp_mem;
      logic [31:0] exp_imm;
      M = 1'b0;
      for (int i = 0; i < 32; i++) begin
         regaddr  = 5'(31 - i);
         dataaddr = 32'(i);
         wbi      = 2'(i);
         exp_q.push_back(32'(i));
         step();
         exp_imm = exp_q.pop_front();
         exp_mem = (i == 1) ? 32'hDEAD_BEEF : (i == 7) ? 32'd6 : 32'd0;
         n_cmp++; if (datafromimm !== exp_imm) begin n_fail++; $display("FAIL stream_imm[%0d]: got %0d want %0d", i, datafromimm, exp_imm); end
         n_cmp++; if (regaddrout !== 5'(31 - i)) begin n_fail++; $display("FAIL stream_regaddr[%0d]: got %0d want %0d", i, regaddrout, 31 - i); end
         n_cmp++; if (wbo !== 2'(i)) begin n_fail++; $display("FAIL stream_wbo[%0d]: got %0d want %0d", i, wbo, i % 4); end
         n_cmp++; if (datafrommem !== exp_mem) begin n_fail++; $display("FAIL stream_mem[%0d]: got %h want %h", i, datafrommem, exp_mem); end
      end
   endtask

   initial begin
      rst = 1'b1; wbi = '0; regaddr = '0; M = 1'b0; data = '0; dataaddr = '0;
      test_reset();
      test_pass_through();
      test_store_load();
      test_wrap();
      test_reset_priority();
      test_back_to_back();
      test_streaming();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

MEM pipeline stage of the MIPS core, between EX/MEM and the write-back stage. It holds a word-addressed data memory that can be written from the execute result. It also acts as the MEM/WB pipeline register: write-back control, destination register, ALU result and memory read data are all presented to WB one clock later.

## Interface
Parameters:
- `DEPTH`, default 32: data memory size in 32-bit words; must be a power of two.
- `AW`, default 5: memory index width, equal to log2(`DEPTH`).

Ports:
- `clk`, input, 1 bit: single clock; all state updates on its rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `wbi`, input, 2 bits: write-back control from EX/MEM (bit1 RegWrite, bit0 MemtoReg).
- `regaddr`, input, 5 bits: destination register number from EX/MEM.
- `M`, input, 1 bit: MemWrite; 1 writes `data` to memory this cycle.
- `data`, input, 32 bits: store data (rt value).
- `dataaddr`, input, 32 bits: ALU result, used as the memory word address.
- `wbo`, output, 2 bits: registered copy of `wbi`.
- `datafrommem`, output, 32 bits: registered memory read data.
- `datafromimm`, output, 32 bits: registered copy of `dataaddr` (ALU result for R-type / immediate write-back).
- `regaddrout`, output, 5 bits: registered copy of `regaddr`.

## Operation
- Memory array: `DEPTH` x 32 bits, word addressed. The index is `dataaddr[AW-1:0]`; upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- Memory contents are all zero at power-up/configuration. `rst` does not alter memory contents.
- Write: on a rising edge with `M`=1 and `rst`=0, `mem[idx]` takes the value of `data`.
- Read: every cycle the array is read at `idx` and the result is registered into `datafrommem`.
- Read-during-write (`M`=1): write-first. `datafrommem` loads the new `data` value, not the old contents.
- Pipeline register: on each rising edge with `rst`=0, `wbo`, `regaddrout` and `datafromimm` load `wbi`, `regaddr` and `dataaddr`.
- `wbi` is passed through unmodified; the stage does not interpret it.
- There is no stall, flush or enable input; the register updates every cycle.
- Reset (`rst`=1 at a rising edge): `wbo`=0, `regaddrout`=0, `datafromimm`=0, `datafrommem`=0.
- Reset has priority over `M`: no memory write occurs in a reset cycle.
- An X or out-of-range `dataaddr` never produces an out-of-bounds access, because only `AW` bits are used.

## Timing
- All outputs are registered, with a latency of 1 clock from the inputs.
- No combinational path from any input to any output.
- Write latency: data written at edge N is returned by a read of the same address at edge N (write-first), and thereafter.
- Back-to-back writes to the same address: the last write wins.
- Reset asserted mid-stream clears the outputs at that edge; the next non-reset edge loads fresh inputs.
- Memory is one synchronous-write/synchronous-read port (block-RAM inferable).

## Test plan
- Reset: drive `rst`=1 for 2 edges with arbitrary inputs. Require all four outputs = 0 and the memory unchanged; a subsequent read of addr 1 returns 0.
- Pass-through: `wbi`=3, `regaddr`=13, `dataaddr`=1, `M`=0. After 1 edge require `wbo`=3, `regaddrout`=13, `datafromimm`=1, `datafrommem`=0.
- Store/load: `data`=10, `dataaddr`=1, `M`=1 for one cycle. Require `datafrommem`=10 at that edge. With `M`=0 and `dataaddr` held at 1, `datafrommem` stays 10; `dataaddr`=2 gives 0.
- Wrap-around: write `0xDEADBEEF` at `dataaddr`=33 (`DEPTH`=32). Require a read at `dataaddr`=1 to return `0xDEADBEEF`.
- Reset priority: `rst`=1 with `M`=1, `dataaddr`=4, `data`=7. Require outputs 0, and a later read of addr 4 returns its prior value (0).
- Streaming: change `regaddr` and `dataaddr` every cycle (0..31). Require each output to equal the previous cycle's input with no dropped or duplicated values.
